mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter and sequencer for the single-port 512x16 data memory (`memory_ip`: 9-bit address, 16-bit data, `rden`/`wren`, registered inputs). It sits between the memory and two masters: requester A, the program/data loader, and requester B, the processor load/store unit. It grants at most one access per cycle and drives the memory from registers. It also tracks in-flight reads so each read result returns only to the requester that issued it.

## Interface
Parameters:
- `ADDR_W`, 9: memory address width.
- `DATA_W`, 16: memory data width.
- `READ_LATENCY`, 1: cycles from the cycle `mem_rden` is driven high to the cycle `mem_q` is valid; legal range 1–4.

Ports (x = a, b; one set per requester):
- `clock`  in  1: single clock; everything updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_x`  in  1: access request; must be held until granted.
- `we_x`  in  1: 1 = write, 0 = read; qualified by `req_x`.
- `addr_x`  in  ADDR_W: access address.
- `wdata_x`  in  DATA_W: write data.
- `gnt_x`  out  1: combinational accept; the request is consumed this cycle.
- `rvalid_x`  out  1: one-cycle pulse; `rdata_x` is valid.
- `rdata_x`  out  DATA_W: read data, registered.
- `mem_address`  out  ADDR_W: to memory `address`.
- `mem_data`  out  DATA_W: to memory `data`.
- `mem_wren`  out  1: to memory `wren`.
- `mem_rden`  out  1: to memory `rden`.
- `mem_q`  in  DATA_W: from memory `q`.

## Operation
- Arbitration is round-robin with a 1-bit `last` pointer (reset value B, so A wins the first tie).
  - Only one `req_x` high: grant it.
  - Both high: grant the requester that is not `last`.
  - `last` updates to the granted requester on every grant.
- At most one of `gnt_a` and `gnt_b` is high in any cycle. A grant is issued only when the matching `req_x` is high in the same cycle.
- Issue register: on a grant, the next cycle drives
  - `mem_address` = `addr_x`,
  - `mem_data` = `wdata_x`,
  - `mem_wren` = `we_x`,
  - `mem_rden` = `!we_x`.
- With no grant, the next cycle has `mem_wren` = `mem_rden` = 0. `mem_address` and `mem_data` hold their previous values.
- Read tracking: a shift pipe of depth `READ_LATENCY` carries {valid, owner} for each read, entered in the same cycle `mem_rden` is driven.
  - When the pipe output is valid, `mem_q` is captured into `rdata_owner` and `rvalid_owner` pulses in the following cycle.
  - The other requester's `rdata` holds its value.
- Writes produce no `rvalid`.
- The arbiter is fully pipelined: back-to-back grants are legal every cycle, mixed reads and writes, in any requester order. Read results return in issue order.
- Read-after-write to the same address issued in consecutive cycles returns the new data, because the memory processes the accesses in order. No forwarding is needed.

## Timing
- Reset values: `gnt_x` = 0 (combinational, forced low while `reset` = 1), `rvalid_x` = 0, `rdata_x` = 0, `mem_wren` = 0, `mem_rden` = 0, `mem_address` = 0, `mem_data` = 0, read pipe cleared, `last` = B.
- Grant in cycle N:
  - `mem_*` driven in cycle N+1;
  - for a read, `mem_q` is valid in cycle N+1+READ_LATENCY;
  - `rvalid_x`/`rdata_x` appear in cycle N+2+READ_LATENCY (N+3 at default).
- A requester may drop `req_x` or change `addr_x` in the cycle after its grant. If it holds `req_x` high, that is a new request.
- Reset mid-operation: all in-flight reads are discarded with no `rvalid`, and memory strobes are low from the cycle after `reset` is sampled. A write already driven to the memory before reset completes in the memory; that is a memory property, not arbiter behaviour.
- Both requesters request continuously: grants strictly alternate A, B, A, B….

## Test plan
- Loader fill: A alone writes 1..8 to addresses 1..8 on consecutive cycles -> `gnt_a` high 8 consecutive cycles; `mem_wren` high 8 cycles, starting one cycle later, with matching address/data; no `rvalid`.
- Single read: after the fill, B reads address 2 at cycle N -> `rvalid_b` = 1 with `rdata_b` = 2 at exactly N+3; `rvalid_a` stays 0.
- Contention: A and B both hold read requests (A: addr 3, 4; B: addr 5, 6) from cycle N -> grants A3, B5, A4, B6 on N..N+3; `rdata_a` returns 3 then 4, `rdata_b` returns 5 then 6, each 3 cycles after its grant.
- Read-after-write: B writes 0xBEEF to address 7 at cycle N, then reads address 7 at N+1 -> `rdata_b` = 0xBEEF at N+4.
- Reset mid-flight: B reads address 1 at N and `reset` is asserted at N+1 -> no `rvalid_b` in any cycle; all outputs return to reset values; the first post-reset tie is granted to A.
- Latency parameter: with `READ_LATENCY` = 3, B reads address 8 -> `rvalid_b` arrives 5 cycles after the grant with `rdata_b` = 8.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Requester and memory-side signal bundle for mem_port_arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              req_a;
    logic              we_a;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] wdata_a;
    logic              gnt_a;
    logic              rvalid_a;
    logic [DATA_W-1:0] rdata_a;

    logic              req_b;
    logic              we_b;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] wdata_b;
    logic              gnt_b;
    logic              rvalid_b;
    logic [DATA_W-1:0] rdata_b;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic              mem_rden;
    logic [DATA_W-1:0] mem_q;

    modport slave (
        input  req_a, we_a, addr_a, wdata_a,
        input  req_b, we_b, addr_b, wdata_b,
        input  mem_q,
        output gnt_a, rvalid_a, rdata_a,
        output gnt_b, rvalid_b, rdata_b,
        output mem_address, mem_data, mem_wren, mem_rden
    );

    modport master (
        output req_a, we_a, addr_a, wdata_a,
        output req_b, we_b, addr_b, wdata_b,
        output mem_q,
        input  gnt_a, rvalid_a, rdata_a,
        input  gnt_b, rvalid_b, rdata_b,
        input  mem_address, mem_data, mem_wren, mem_rden
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin two-requester arbiter for a single-port memory; tracks in-flight
// reads so each result is returned only to the requester that issued it.
module mem_port_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 1
) (
    input logic               clock,
    input logic               reset,
    mem_port_arbiter_if.slave bus
);
    logic                    last_b;
    logic                    issue_owner_b;
    logic                    gnt_a;
    logic                    gnt_b;
    logic                    sel_we;
    logic [ADDR_W-1:0]       sel_addr;
    logic [DATA_W-1:0]       sel_wdata;
    logic [READ_LATENCY-1:0] pipe_valid;
    logic [READ_LATENCY-1:0] pipe_owner_b;

    // On a tie the requester that did not win last time goes first.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (!reset) begin
            if (bus.req_a && (!bus.req_b || last_b)) begin
                gnt_a = 1'b1;
            end else if (bus.req_b) begin
                gnt_b = 1'b1;
            end
        end
    end

    assign bus.gnt_a = gnt_a;
    assign bus.gnt_b = gnt_b;

    assign sel_we    = gnt_b ? bus.we_b    : bus.we_a;
    assign sel_addr  = gnt_b ? bus.addr_b  : bus.addr_a;
    assign sel_wdata = gnt_b ? bus.wdata_b : bus.wdata_a;

    always_ff @(posedge clock) begin
        if (reset) begin
            last_b          <= 1'b1;
            issue_owner_b   <= 1'b0;
            bus.mem_address <= '0;
            bus.mem_data    <= '0;
            bus.mem_wren    <= 1'b0;
            bus.mem_rden    <= 1'b0;
        end else if (gnt_a || gnt_b) begin
            last_b          <= gnt_b;
            issue_owner_b   <= gnt_b;
            bus.mem_address <= sel_addr;
            bus.mem_data    <= sel_wdata;
            bus.mem_wren    <= sel_we;
            bus.mem_rden    <= !sel_we;
        end else begin
            bus.mem_wren    <= 1'b0;
            bus.mem_rden    <= 1'b0;
        end
    end

    // The pipe output lines up with the cycle mem_q carries that read's data.
    always_ff @(posedge clock) begin
        if (reset) begin
            pipe_valid   <= '0;
            pipe_owner_b <= '0;
            bus.rvalid_a <= 1'b0;
            bus.rvalid_b <= 1'b0;
            bus.rdata_a  <= '0;
            bus.rdata_b  <= '0;
        end else begin
            pipe_valid[0]   <= bus.mem_rden;
            pipe_owner_b[0] <= issue_owner_b;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_valid[i]   <= pipe_valid[i-1];
                pipe_owner_b[i] <= pipe_owner_b[i-1];
            end
            bus.rvalid_a <= pipe_valid[READ_LATENCY-1] && !pipe_owner_b[READ_LATENCY-1];
            bus.rvalid_b <= pipe_valid[READ_LATENCY-1] &&  pipe_owner_b[READ_LATENCY-1];
            if (pipe_valid[READ_LATENCY-1]) begin
                if (pipe_owner_b[READ_LATENCY-1]) begin
                    bus.rdata_b <= bus.mem_q;
                end else begin
                    bus.rdata_a <= bus.mem_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share one
// stimulus stream and are compared every cycle against a transaction-level model.
module tb_mem_port_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus1 ();
    mem_port_arbiter_if #(.ADDR_W(9), .DATA_W(16)) bus3 ();

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(16), .READ_LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1.slave)
    );

    mem_port_arbiter #(.ADDR_W(9), .DATA_W(16), .READ_LATENCY(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (bus3.slave)
    );

    assign bus3.req_a   = bus1.req_a;
    assign bus3.we_a    = bus1.we_a;
    assign bus3.addr_a  = bus1.addr_a;
    assign bus3.wdata_a = bus1.wdata_a;
    assign bus3.req_b   = bus1.req_b;
    assign bus3.we_b    = bus1.we_b;
    assign bus3.addr_b  = bus1.addr_b;
    assign bus3.wdata_b = bus1.wdata_b;

    // Memory models with registered inputs, one per read latency.
    logic [15:0] mem1 [512] = '{default: '0};
    logic [15:0] mem3 [512] = '{default: '0};
    logic [15:0] q1         = '0;
    logic [15:0] qp3 [3]    = '{default: '0};

    always @(posedge clock) begin
        if (bus1.mem_wren) mem1[bus1.mem_address] <= bus1.mem_data;
        if (bus1.mem_rden) q1 <= mem1[bus1.mem_address];
    end

    always @(posedge clock) begin
        if (bus3.mem_wren) mem3[bus3.mem_address] <= bus3.mem_data;
        if (bus3.mem_rden) qp3[0] <= mem3[bus3.mem_address];
        qp3[1] <= qp3[0];
        qp3[2] <= qp3[1];
    end

    assign bus1.mem_q = q1;
    assign bus3.mem_q = qp3[2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, actual, expected);
        end
    endtask

    // Transaction-level model: reads are answered with the memory contents as of
    // their grant, delivered 2+latency cycles later to the issuing requester.
    typedef struct {
        int          grant;
        logic        owner_b;
        logic [15:0] data;
    } rd_t;

    rd_t         rq[$];
    rd_t         ent;
    logic        m_last_b  = 1'b1;
    logic [8:0]  m_addr    = '0;
    logic [15:0] m_data    = '0;
    logic        m_wren    = 1'b0;
    logic        m_rden    = 1'b0;
    logic [15:0] m_rdata [2][2] = '{default: '0};
    logic [15:0] model_mem [512] = '{default: '0};
    int          lat_of [2] = '{1, 3};
    logic        win_a, win_b, w_we;
    logic [8:0]  w_addr;
    logic [15:0] w_data;
    logic [1:0]  v;

    always @(negedge clock) begin
        win_a = 1'b0;
        win_b = 1'b0;
        if (!reset) begin
            if (bus1.req_a && bus1.req_b) begin
                win_a = m_last_b;
                win_b = !m_last_b;
            end else begin
                win_a = bus1.req_a;
                win_b = bus1.req_b;
            end
        end

        checkOutput("lat1_gnt_a", 32'(bus1.gnt_a), 32'(win_a));
        checkOutput("lat1_gnt_b", 32'(bus1.gnt_b), 32'(win_b));
        checkOutput("lat3_gnt_a", 32'(bus3.gnt_a), 32'(win_a));
        checkOutput("lat3_gnt_b", 32'(bus3.gnt_b), 32'(win_b));
        checkOutput("lat1_mem_wren", 32'(bus1.mem_wren), 32'(m_wren));
        checkOutput("lat1_mem_rden", 32'(bus1.mem_rden), 32'(m_rden));
        checkOutput("lat1_mem_address", 32'(bus1.mem_address), 32'(m_addr));
        checkOutput("lat1_mem_data", 32'(bus1.mem_data), 32'(m_data));
        checkOutput("lat3_mem_wren", 32'(bus3.mem_wren), 32'(m_wren));
        checkOutput("lat3_mem_rden", 32'(bus3.mem_rden), 32'(m_rden));
        checkOutput("lat3_mem_address", 32'(bus3.mem_address), 32'(m_addr));
        checkOutput("lat3_mem_data", 32'(bus3.mem_data), 32'(m_data));

        for (int d = 0; d < 2; d++) begin
            v = 2'b00;
            foreach (rq[i]) begin
                if (rq[i].grant + 2 + lat_of[d] == cyc) begin
                    v[rq[i].owner_b] = 1'b1;
                    m_rdata[d][rq[i].owner_b] = rq[i].data;
                end
            end
            checkOutput($sformatf("lat%0d_rvalid_a", lat_of[d]),
                        32'(d == 0 ? bus1.rvalid_a : bus3.rvalid_a), 32'(v[0]));
            checkOutput($sformatf("lat%0d_rvalid_b", lat_of[d]),
                        32'(d == 0 ? bus1.rvalid_b : bus3.rvalid_b), 32'(v[1]));
            checkOutput($sformatf("lat%0d_rdata_a", lat_of[d]),
                        32'(d == 0 ? bus1.rdata_a : bus3.rdata_a), 32'(m_rdata[d][0]));
            checkOutput($sformatf("lat%0d_rdata_b", lat_of[d]),
                        32'(d == 0 ? bus1.rdata_b : bus3.rdata_b), 32'(m_rdata[d][1]));
        end

        if (reset) begin
            rq.delete();
            m_last_b = 1'b1;
            m_addr   = '0;
            m_data   = '0;
            m_wren   = 1'b0;
            m_rden   = 1'b0;
            m_rdata  = '{default: '0};
        end else begin
            while (rq.size() > 0 && rq[0].grant + 5 <= cyc) void'(rq.pop_front());
            if (win_a || win_b) begin
                w_we     = win_b ? bus1.we_b    : bus1.we_a;
                w_addr   = win_b ? bus1.addr_b  : bus1.addr_a;
                w_data   = win_b ? bus1.wdata_b : bus1.wdata_a;
                m_addr   = w_addr;
                m_data   = w_data;
                m_wren   = w_we;
                m_rden   = !w_we;
                m_last_b = win_b;
                if (w_we) begin
                    model_mem[w_addr] = w_data;
                end else begin
                    ent.grant   = cyc;
                    ent.owner_b = win_b;
                    ent.data    = model_mem[w_addr];
                    rq.push_back(ent);
                end
            end else begin
                m_wren = 1'b0;
                m_rden = 1'b0;
            end
        end
    end

    // Drive the inputs for the current cycle and return at its falling edge.
    task automatic applyStimulus(input logic ra, input logic wa, input logic [8:0] aa, input logic [15:0] da,
                                 input logic rb, input logic wb, input logic [8:0] ab, input logic [15:0] db);
        bus1.req_a   = ra;
        bus1.we_a    = wa;
        bus1.addr_a  = aa;
        bus1.wdata_a = da;
        bus1.req_b   = rb;
        bus1.we_b    = wb;
        bus1.addr_b  = ab;
        bus1.wdata_b = db;
        @(negedge clock);
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, 1'b0, 9'd0, 16'd0, 1'b0, 1'b0, 9'd0, 16'd0);
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    logic        pend_a = 1'b0, pend_b = 1'b0;
    logic        rwe_a = 1'b0, rwe_b = 1'b0;
    logic [8:0]  raddr_a = '0, raddr_b = '0;
    logic [15:0] rdat_a = '0, rdat_b = '0;

    initial begin
        reset = 1'b1;
        bus1.req_a = 1'b1; bus1.we_a = 1'b0; bus1.addr_a = '0; bus1.wdata_a = '0;
        bus1.req_b = 1'b1; bus1.we_b = 1'b0; bus1.addr_b = '0; bus1.wdata_b = '0;
        nextCycle();
        nextCycle();
        @(negedge clock);
        checkOutput("reset_gnt_a", 32'(bus1.gnt_a), 32'd0);
        checkOutput("reset_gnt_b", 32'(bus1.gnt_b), 32'd0);
        checkOutput("reset_mem_rden", 32'(bus1.mem_rden), 32'd0);
        checkOutput("reset_rdata_b", 32'(bus1.rdata_b), 32'd0);
        nextCycle();
        reset = 1'b0;

        // Loader fill: A writes i to address i.
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b1, 9'(i), 16'(i), 1'b0, 1'b0, 9'd0, 16'd0);
            checkOutput("fill_gnt_a", 32'(bus1.gnt_a), 32'd1);
            if (i == 2) begin
                checkOutput("fill_mem_wren", 32'(bus1.mem_wren), 32'd1);
                checkOutput("fill_mem_address", 32'(bus1.mem_address), 32'd1);
                checkOutput("fill_mem_data", 32'(bus1.mem_data), 32'd1);
            end
            nextCycle();
        end
        applyIdle();
        nextCycle();

        // Single reads by B: address 2, then address 8.
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k <= 6; k++) begin
                if (k == 0) applyStimulus(1'b0, 1'b0, 9'd0, 16'd0, 1'b1, 1'b0, (r == 0) ? 9'd2 : 9'd8, 16'd0);
                else applyIdle();
                if (k == 3) begin
                    checkOutput("read_lat1_rvalid_b", 32'(bus1.rvalid_b), 32'd1);
                    checkOutput("read_lat1_rdata_b", 32'(bus1.rdata_b), (r == 0) ? 32'd2 : 32'd8);
                    checkOutput("read_lat1_rvalid_a", 32'(bus1.rvalid_a), 32'd0);
                end
                if (k == 5) begin
                    checkOutput("read_lat3_rvalid_b", 32'(bus3.rvalid_b), 32'd1);
                    checkOutput("read_lat3_rdata_b", 32'(bus3.rdata_b), (r == 0) ? 32'd2 : 32'd8);
                end
                nextCycle();
            end
        end

        // Contention: A reads 3,4 and B reads 5,6, each holding until granted.
        for (int k = 0; k <= 8; k++) begin
            case (k)
                0: applyStimulus(1'b1, 1'b0, 9'd3, 16'd0, 1'b1, 1'b0, 9'd5, 16'd0);
                1: applyStimulus(1'b1, 1'b0, 9'd4, 16'd0, 1'b1, 1'b0, 9'd5, 16'd0);
                2: applyStimulus(1'b1, 1'b0, 9'd4, 16'd0, 1'b1, 1'b0, 9'd6, 16'd0);
                3: applyStimulus(1'b0, 1'b0, 9'd0, 16'd0, 1'b1, 1'b0, 9'd6, 16'd0);
                default: applyIdle();
            endcase
            if (k == 0 || k == 2) checkOutput("cont_gnt_a", 32'(bus1.gnt_a), 32'd1);
            if (k == 1 || k == 3) checkOutput("cont_gnt_b", 32'(bus1.gnt_b), 32'd1);
            if (k == 3) checkOutput("cont_rdata_a0", 32'(bus1.rdata_a), 32'd3);
            if (k == 4) checkOutput("cont_rdata_b0", 32'(bus1.rdata_b), 32'd5);
            if (k == 5) checkOutput("cont_rdata_a1", 32'(bus1.rdata_a), 32'd4);
            if (k == 6) checkOutput("cont_rdata_b1", 32'(bus1.rdata_b), 32'd6);
            nextCycle();
        end

        // Read-after-write on address 7.
        for (int k = 0; k <= 6; k++) begin
            case (k)
                0: applyStimulus(1'b0, 1'b0, 9'd0, 16'd0, 1'b1, 1'b1, 9'd7, 16'hBEEF);
                1: applyStimulus(1'b0, 1'b0, 9'd0, 16'd0, 1'b1, 1'b0, 9'd7, 16'd0);
                default: applyIdle();
            endcase
            if (k == 4) checkOutput("raw_lat1_rdata_b", 32'(bus1.rdata_b), 32'hBEEF);
            if (k == 6) checkOutput("raw_lat3_rdata_b", 32'(bus3.rdata_b), 32'hBEEF);
            nextCycle();
        end

        // Reset while a read is in flight, then a tie right after reset.
        for (int k = 0; k <= 8; k++) begin
            reset = (k == 1);
            case (k)
                0: applyStimulus(1'b0, 1'b0, 9'd0, 16'd0, 1'b1, 1'b0, 9'd1, 16'd0);
                8: applyStimulus(1'b1, 1'b0, 9'd2, 16'd0, 1'b1, 1'b0, 9'd3, 16'd0);
                default: applyIdle();
            endcase
            if (k >= 2) begin
                checkOutput("rst_lat1_rvalid_b", 32'(bus1.rvalid_b), 32'd0);
                checkOutput("rst_lat3_rvalid_b", 32'(bus3.rvalid_b), 32'd0);
            end
            if (k == 2) begin
                checkOutput("rst_mem_rden", 32'(bus1.mem_rden), 32'd0);
                checkOutput("rst_mem_address", 32'(bus1.mem_address), 32'd0);
            end
            if (k == 8) checkOutput("rst_tie_gnt_a", 32'(bus1.gnt_a), 32'd1);
            nextCycle();
        end
        applyIdle();
        nextCycle();

        // Random traffic: each requester holds a pending access until granted.
        for (int t = 0; t < 1500; t++) begin
            if (!pend_a && $urandom_range(0, 2) != 0) begin
                pend_a  = 1'b1;
                rwe_a   = 1'($urandom_range(0, 1));
                raddr_a = 9'($urandom_range(0, 15));
                rdat_a  = 16'($urandom);
            end
            if (!pend_b && $urandom_range(0, 2) != 0) begin
                pend_b  = 1'b1;
                rwe_b   = 1'($urandom_range(0, 1));
                raddr_b = 9'($urandom_range(0, 15));
                rdat_b  = 16'($urandom);
            end
            reset = ($urandom_range(0, 299) == 0);
            applyStimulus(pend_a, rwe_a, raddr_a, rdat_a, pend_b, rwe_b, raddr_b, rdat_b);
            if (bus1.gnt_a) pend_a = 1'b0;
            if (bus1.gnt_b) pend_b = 1'b0;
            nextCycle();
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            applyIdle();
            nextCycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
